// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU sequencing controller: op encoding, FSM state
// type, default latencies, and the counter-width helper.
// Optional feature macro: MDU_MADD_EN (enables op 7 MADD; otherwise op 7 acts as NONE).
package mdu_pkg;

  // MDU op encoding as issued by the decode stage
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  // Default latencies from start to HI/LO commit
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter width: clog2 of the longer latency. The counter only ever holds
  // N-1, so clog2(N) bits suffice; at least one bit is kept so the vector
  // stays legal when both latencies are 1.
  function automatic int mdu_cnt_w(input int mult_cycles, input int div_cycles);
    int mx;
    mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    if (mx <= 2) return 1;
    return $clog2(mx);
  endfunction

  // An op is accepted only if it does real work in this build.
  function automatic logic op_is_legal(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op != OP_NONE);
`else
    return (op != OP_NONE) && (op != OP_MADD);
`endif
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational 32-bit signed/unsigned divider for the MDU.
// Quotient truncates toward zero, remainder takes the sign of the dividend.
// A zero divisor raises div_zero; the quotient/remainder are then don't-care.
// Kept as its own block so an iterative divider can replace it later.
module mdu_div_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] uq;
  logic [31:0] ur;

  // Sign/magnitude split. 0x80000000 negates to itself, which is exactly
  // 2^31 as an unsigned magnitude, so 0x80000000 / -1 yields a magnitude
  // quotient of 2^31 that negates back to 0x80000000 with remainder 0.
  assign a_neg = is_signed & a[31];
  assign b_neg = is_signed & b[31];
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;

  // Divide-by-zero is flagged; a dummy divisor of 1 keeps the divider
  // free of X propagation in that case.
  assign div_zero = (b == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_mag;

  assign uq = a_mag / b_safe;
  assign ur = a_mag % b_safe;

  assign quot = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem  = a_neg ? (32'd0 - ur) : ur;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller for the E stage.
// Accepts one MDU op, holds busy for a fixed latency, then commits to HI/LO.
// MTHI/MTLO complete in a single cycle without entering RUN.
// A same-cycle int_req cancels an issue; int_req during RUN does not abort.
// Optional feature macro: MDU_MADD_EN (op 7 MADD accumulates into {hi,lo}).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        int_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = mdu_cnt_w(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;

  logic               accept;
  logic               is_div_op;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  logic               div_signed;
  logic [31:0]        div_quot;
  logic [31:0]        div_rem;
  logic               div_zero;

  logic               hilo_we;
  logic [63:0]        hilo_nxt;

  // Issue qualification: only from IDLE, never on an interrupt cycle.
  assign accept    = (state_q == ST_IDLE) & start & ~int_req & op_is_legal(op);
  assign is_div_op = (op == OP_DIV) | (op == OP_DIVU);

  // Multiplier works on the latched operands. The low 64 bits of the product
  // of sign-extended (or zero-extended) operands give the signed (unsigned)
  // 64-bit result directly.
  assign prod_s = $signed({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  assign div_signed = (op_q == OP_DIV);

  mdu_div_core u_div (
    .a        (a_q),
    .b        (b_q),
    .is_signed(div_signed),
    .quot     (div_quot),
    .rem      (div_rem),
    .div_zero (div_zero)
  );

  // Select the HI/LO value written on the commit edge of the in-flight op.
  always_comb begin
    hilo_we  = 1'b0;
    hilo_nxt = {hi, lo};
    case (op_q)
      OP_MULT: begin
        hilo_we  = 1'b1;
        hilo_nxt = prod_s;
      end
      OP_MULTU: begin
        hilo_we  = 1'b1;
        hilo_nxt = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        // Divide by zero leaves HI/LO untouched but still completes.
        hilo_we  = ~div_zero;
        hilo_nxt = {div_rem, div_quot};
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        // Accumulator is sampled at the commit edge, wraps modulo 2^64.
        hilo_we  = 1'b1;
        hilo_nxt = {hi, lo} + prod_s;
      end
`endif
      default: begin
        hilo_we  = 1'b0;
        hilo_nxt = {hi, lo};
      end
    endcase
  end

  // Control FSM with registered busy/done and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MTHI) begin
              hi   <= a;
              done <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo   <= a;
              done <= 1'b1;
            end else begin
              op_q    <= op;
              a_q     <= a;
              b_q     <= b;
              cnt_q   <= is_div_op ? DIV_LOAD : MULT_LOAD;
              state_q <= ST_RUN;
              busy    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // New issues are ignored here, including on the commit edge.
          if (cnt_q == '0) begin
            if (hilo_we) begin
              {hi, lo} <= hilo_nxt;
            end
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboarded HI/LO results and latency.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = OP_NONE;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        int_req = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .int_req(int_req),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one issue cycle; returns on the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic ir);
    op = o; a = x; b = y; int_req = ir; start = 1'b1;
    @(negedge clk);
    start = 1'b0; int_req = 1'b0; op = OP_NONE;
  endtask

  // Count busy samples until done appears, bounded.
  task automatic wait_done(output int bc, output bit seen);
    bc = 0; seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      @(negedge clk);
    end
  endtask

  // Issue a scoreboarded op, wait for its completion and pop its expectation.
  task automatic exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      output int bc, output bit seen, output exp_t e);
    issue(o, x, y, 1'b0);
    wait_done(bc, seen);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    logic [2:0]  ops[3] = '{OP_MULT, OP_MULTU, OP_MULT};
    logic [31:0] xa[3]  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000};
    logic [31:0] xb[3]  = '{32'd3, 32'd3, 32'h80000000};
    logic [31:0] eh[3]  = '{32'hFFFFFFFF, 32'h00000002, 32'h40000000};
    logic [31:0] el[3]  = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'h00000000};
    int bc; bit seen; exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({eh[i], el[i], 8'(MULT_N)});
      exec(ops[i], xa[i], xb[i], bc, seen, e);
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL mult[%0d] done: no pulse within bound", i); end
      n_cmp++; if (bc !== int'(e.lat)) begin n_fail++; $display("FAIL mult[%0d] busy_cycles: got %0d want %0d", i, bc, e.lat); end
      n_cmp++; if (hi !== e.hi) begin n_fail++; $display("FAIL mult[%0d] hi: got %h want %h", i, hi, e.hi); end
      n_cmp++; if (lo !== e.lo) begin n_fail++; $display("FAIL mult[%0d] lo: got %h want %h", i, lo, e.lo); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult[%0d] done_width: got %b want 0", i, done); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops[4] = '{OP_DIV, OP_DIV, OP_DIV, OP_DIVU};
    logic [31:0] xa[4]  = '{32'hFFFFFFF9, 32'd5, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] xb[4]  = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'h10};
    logic [31:0] eh[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0000000F};
    logic [31:0] el[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h0FFFFFFF};
    int bc; bit seen; exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({eh[i], el[i], 8'(DIV_N)});
      exec(ops[i], xa[i], xb[i], bc, seen, e);
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL div[%0d] done: no pulse within bound", i); end
      n_cmp++; if (bc !== int'(e.lat)) begin n_fail++; $display("FAIL div[%0d] busy_cycles: got %0d want %0d", i, bc, e.lat); end
      n_cmp++; if (hi !== e.hi) begin n_fail++; $display("FAIL div[%0d] hi: got %h want %h", i, hi, e.hi); end
      n_cmp++; if (lo !== e.lo) begin n_fail++; $display("FAIL div[%0d] lo: got %h want %h", i, lo, e.lo); end
      @(negedge clk);
    end
  endtask

  task automatic test_mtx;
    int bc; bit seen; exp_t e; bit act;
    // Interrupt on the issue cycle: nothing may happen.
    issue(OP_MTLO, 32'h1234, 32'd0, 1'b1);
    act = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (busy || done) act = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (act) begin n_fail++; $display("FAIL mtlo_int activity: got busy/done want none"); end
    n_cmp++; if (lo !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL mtlo_int lo: got %h want 0fffffff", lo); end
    // Plain MTLO then MTHI: one-cycle, no busy.
    sb.push_back({32'h0000000F, 32'h00001234, 8'd0});
    exec(OP_MTLO, 32'h1234, 32'd0, bc, seen, e);
    n_cmp++; if (!seen || bc !== 0) begin n_fail++; $display("FAIL mtlo timing: got seen=%0d busy_cycles=%0d want 1/0", seen, bc); end
    n_cmp++; if (lo !== e.lo) begin n_fail++; $display("FAIL mtlo lo: got %h want %h", lo, e.lo); end
    n_cmp++; if (hi !== e.hi) begin n_fail++; $display("FAIL mtlo hi: got %h want %h", hi, e.hi); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mtlo after: got done=%b busy=%b want 0/0", done, busy); end
    sb.push_back({32'h0000ABCD, 32'h00001234, 8'd0});
    exec(OP_MTHI, 32'hABCD, 32'd0, bc, seen, e);
    n_cmp++; if (!seen || bc !== 0) begin n_fail++; $display("FAIL mthi timing: got seen=%0d busy_cycles=%0d want 1/0", seen, bc); end
    n_cmp++; if (hi !== e.hi) begin n_fail++; $display("FAIL mthi hi: got %h want %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_fail++; $display("FAIL mthi lo: got %h want %h", lo, e.lo); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int bc; bit seen; exp_t e; bit act;
    sb.push_back({32'd2, 32'd14, 8'(DIV_N)});
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    bc = 0; seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      if (k == 2) begin start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5; end
      else begin start = 1'b0; op = OP_NONE; end
      @(negedge clk);
    end
    start = 1'b0; op = OP_NONE;
    e = sb.pop_front();
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL swb done: no pulse within bound"); end
    n_cmp++; if (bc !== int'(e.lat)) begin n_fail++; $display("FAIL swb busy_cycles: got %0d want %0d", bc, e.lat); end
    n_cmp++; if (hi !== e.hi) begin n_fail++; $display("FAIL swb hi: got %h want %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_fail++; $display("FAIL swb lo: got %h want %h", lo, e.lo); end
    act = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy || done) act = 1'b1;
    end
    n_cmp++; if (act) begin n_fail++; $display("FAIL swb stray_op: got activity want none"); end
    n_cmp++; if (lo !== 32'd14) begin n_fail++; $display("FAIL swb lo_after: got %h want 0000000e", lo); end
  endtask

  task automatic test_back_to_back;
    int bc; bit seen; exp_t e; bit act;
    sb.push_back({32'd0, 32'd42, 8'(MULT_N)});
    issue(OP_MULT, 32'd6, 32'd7, 1'b0);
    bc = 0; seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      // Hold an issue across the commit edge; it must be rejected.
      if (k == MULT_N - 1) begin start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9; end
      @(negedge clk);
    end
    start = 1'b0; op = OP_NONE;
    e = sb.pop_front();
    n_cmp++; if (!seen || bc !== int'(e.lat)) begin n_fail++; $display("FAIL b2b timing: got seen=%0d busy_cycles=%0d want 1/%0d", seen, bc, e.lat); end
    n_cmp++; if (lo !== e.lo || hi !== e.hi) begin n_fail++; $display("FAIL b2b result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
    act = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy || done) act = 1'b1;
    end
    n_cmp++; if (act) begin n_fail++; $display("FAIL b2b rejected_issue: got activity want none"); end
    sb.push_back({32'd0, 32'd4, 8'(MULT_N)});
    exec(OP_MULT, 32'd2, 32'd2, bc, seen, e);
    n_cmp++; if (!seen || bc !== int'(e.lat)) begin n_fail++; $display("FAIL b2b reissue timing: got seen=%0d busy_cycles=%0d want 1/%0d", seen, bc, e.lat); end
    n_cmp++; if (lo !== e.lo || hi !== e.hi) begin n_fail++; $display("FAIL b2b reissue result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
    @(negedge clk);
  endtask

  task automatic test_madd;
`ifdef MDU_MADD_EN
    logic [2:0]  ops[4] = '{OP_MTHI, OP_MTLO, OP_MADD, OP_MADD};
    logic [31:0] xa[4]  = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
    logic [31:0] xb[4]  = '{32'd0, 32'd0, 32'd1, 32'd1};
    logic [31:0] eh[4]  = '{32'd0, 32'd0, 32'd1, 32'd0};
    logic [31:0] el[4]  = '{32'd4, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [7:0]  lt[4]  = '{8'd0, 8'd0, 8'(MULT_N), 8'(MULT_N)};
    int bc; bit seen; exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({eh[i], el[i], lt[i]});
      exec(ops[i], xa[i], xb[i], bc, seen, e);
      n_cmp++; if (!seen || bc !== int'(e.lat)) begin n_fail++; $display("FAIL madd[%0d] timing: got seen=%0d busy_cycles=%0d want 1/%0d", i, seen, bc, e.lat); end
      n_cmp++; if (hi !== e.hi) begin n_fail++; $display("FAIL madd[%0d] hi: got %h want %h", i, hi, e.hi); end
      n_cmp++; if (lo !== e.lo) begin n_fail++; $display("FAIL madd[%0d] lo: got %h want %h", i, lo, e.lo); end
      @(negedge clk);
    end
`else
    bit act;
    issue(OP_MADD, 32'd1, 32'd1, 1'b0);
    act = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (busy || done) act = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (act) begin n_fail++; $display("FAIL madd_off activity: got busy/done want none"); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd4) begin n_fail++; $display("FAIL madd_off hilo: got %h_%h want 00000000_00000004", hi, lo); end
`endif
  endtask

  task automatic test_reset_mid_op;
    bit act;
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid hilo: got %h_%h want 0_0", hi, lo); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    act = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy || done) act = 1'b1;
    end
    n_cmp++; if (act) begin n_fail++; $display("FAIL rst_mid commit: got busy/done after abort want none"); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid hilo_after: got %h_%h want 0_0", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mtx();
    test_start_while_busy();
    test_back_to_back();
    test_madd();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
